// File: rtl/rr_packet_arbiter.sv
// rr_packet_arbiter: round-robin arbiter that lets N requesters share one
// ready/valid sink with multi-beat packet locking. A requester that wins
// keeps the grant until it transfers a beat with last set.
// Optional build macro RR_PACKET_ARBITER_OUT_REG_EN inserts a one-entry
// output register on out_* (1-cycle latency, full throughput). Without the
// macro the input-to-output path is purely combinational.
module rr_packet_arbiter #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [N*W-1:0] in_bits,
  input  logic [N-1:0]   in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_bits,
  output logic           out_last,
  output logic [IW-1:0]  out_chosen,
  output logic           locked
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] ptr_reg, ptr_next;
  logic [IW-1:0] owner_reg, owner_next;

  // Candidates in round-robin priority order, starting at ptr.
  logic [IW-1:0] cand_idx [N];
  logic [N-1:0]  cand_valid;

  logic          search_found;
  logic [IW-1:0] search_idx;

  logic          gnt_active;   // some requester currently holds the grant
  logic [IW-1:0] gnt_idx;
  logic          gnt_valid;    // granted requester is offering a beat
  logic          gnt_last;
  logic [W-1:0]  gnt_bits;
  logic          accept;       // the output side can take a beat this cycle
  logic          xfer;         // input-side transfer on the granted requester

  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    assign cand_idx[gi]   = ptr_reg + IW'(gi);
    assign cand_valid[gi] = in_valid[cand_idx[gi]];
  end

  // First valid requester at or after ptr, wrapping modulo N.
  always_comb begin
    search_found = 1'b0;
    search_idx   = ptr_reg;
    for (int k = 0; k < N; k++) begin
      if (!search_found && cand_valid[k]) begin
        search_found = 1'b1;
        search_idx   = cand_idx[k];
      end
    end
  end

  // While a packet is open the owner keeps the grant even when it is idle.
  assign gnt_active = (state_reg == LOCKED) ? 1'b1 : search_found;
  assign gnt_idx    = (state_reg == LOCKED) ? owner_reg : search_idx;
  assign gnt_valid  = gnt_active & in_valid[gnt_idx];
  assign gnt_last   = in_last[gnt_idx];
  assign gnt_bits   = in_bits[gnt_idx*W +: W];
  assign xfer       = gnt_valid & accept;
  assign locked     = (state_reg == LOCKED);

  // Only the granted requester can ever see ready.
  for (genvar gi = 0; gi < N; gi++) begin : g_ready
    assign in_ready[gi] = gnt_active && (gnt_idx == IW'(gi)) && accept;
  end

`ifdef RR_PACKET_ARBITER_OUT_REG_EN
  logic          out_valid_reg;
  logic [W-1:0]  out_bits_reg;
  logic          out_last_reg;
  logic [IW-1:0] out_chosen_reg;

  // The register may refill in the same cycle it drains.
  assign accept = !out_valid_reg | out_ready;

  // One-entry output stage: load on input transfer, drain on sink accept.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_reg  <= 1'b0;
      out_bits_reg   <= '0;
      out_last_reg   <= 1'b0;
      out_chosen_reg <= '0;
    end else if (xfer) begin
      out_valid_reg  <= 1'b1;
      out_bits_reg   <= gnt_bits;
      out_last_reg   <= gnt_last;
      out_chosen_reg <= gnt_idx;
    end else if (out_ready) begin
      out_valid_reg  <= 1'b0;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_bits   = out_bits_reg;
  assign out_last   = out_last_reg;
  assign out_chosen = out_chosen_reg;
`else
  logic [IW-1:0] chosen_reg;

  assign accept     = out_ready;
  assign out_valid  = gnt_valid;
  assign out_bits   = gnt_bits;
  assign out_last   = gnt_last;
  // out_chosen keeps the last granted index while nothing is offered.
  assign out_chosen = gnt_valid ? gnt_idx : chosen_reg;

  // Remember the most recently offered requester index.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chosen_reg <= '0;
    end else begin
      chosen_reg <= out_chosen;
    end
  end
`endif

  // FSM, round-robin pointer and owner registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
    end
  end

  // Advance on an input-side transfer only; otherwise everything holds.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    if (xfer) begin
      if (gnt_last) begin
        state_next = IDLE;
        ptr_next   = gnt_idx + IW'(1);
      end else if (state_reg == IDLE) begin
        state_next = LOCKED;
        owner_next = gnt_idx;
      end
    end
  end

endmodule
